// File: rtl/div12x6_seq.sv
// rtl/div12x6_seq.sv - sequential restoring divider, 2N-bit dividend by N-bit divisor
//
// Produces one quotient bit per clock, MSB first, and is the inverse of the
// 6x6 multiplier that sits beside it in the arithmetic datapath.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   in_valid     operands valid
//   in_ready     divider can accept operands (registered)
//   dividend     2N-bit unsigned dividend
//   divisor      N-bit unsigned divisor
//   out_valid    result valid, held until accepted (registered)
//   out_ready    consumer accepts the result
//   quotient     2N-bit unsigned quotient (registered)
//   remainder    N-bit unsigned remainder (registered)
//   div_by_zero  divisor was zero (registered)
//   q_ovf        quotient does not fit in N bits (registered)
module div12x6_seq #(
    parameter int N = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero,
    output logic           q_ovf
);

    localparam int W  = 2 * N;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state;
    logic [W-1:0]   d_q;      // dividend, shifted left one bit per step
    logic [N-1:0]   dvs_q;    // captured divisor
    logic [N:0]     r_q;      // partial remainder, one bit wider than the divisor
    logic [W-1:0]   q_q;      // quotient being assembled
    logic [CW-1:0]  cnt;      // step counter, 0 .. W-1
    logic           dz_q;     // captured divisor was zero

    logic [N:0]     r_shift;
    logic [N:0]     r_next;
    logic           step_ge;
    logic [W-1:0]   q_next;

    // One restoring step: bring down the next dividend bit, subtract the
    // divisor when it fits.
    always_comb begin
        r_shift = {r_q[N-1:0], d_q[W-1]};
        step_ge = (r_shift >= {1'b0, dvs_q});
        r_next  = step_ge ? (r_shift - {1'b0, dvs_q}) : r_shift;
        q_next  = {q_q[W-2:0], step_ge};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            q_ovf       <= 1'b0;
            d_q         <= '0;
            dvs_q       <= '0;
            r_q         <= '0;
            q_q         <= '0;
            cnt         <= '0;
            dz_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        d_q      <= dividend;
                        dvs_q    <= divisor;
                        r_q      <= '0;
                        q_q      <= '0;
                        in_ready <= 1'b0;
                        dz_q     <= (divisor == '0);
                        // A zero divisor skips straight to the final step so
                        // its result appears one cycle after the accept edge.
                        cnt      <= (divisor == '0) ? CW'(W - 1) : '0;
                        state    <= RUN;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end

                RUN: begin
                    d_q <= d_q << 1;
                    r_q <= r_next;
                    q_q <= q_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        if (dz_q) begin
                            // d_q has not been shifted on this path, so its
                            // low bits are still the original dividend.
                            quotient    <= '1;
                            remainder   <= d_q[N-1:0];
                            div_by_zero <= 1'b1;
                            q_ovf       <= 1'b1;
                        end else begin
                            quotient    <= q_next;
                            remainder   <= r_next[N-1:0];
                            div_by_zero <= 1'b0;
                            q_ovf       <= |q_next[W-1:N];
                        end
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div12x6_seq.sv
// tb/tb_div12x6_seq.sv - directed and swept checks for div12x6_seq
module tb_div12x6_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] dividend;
    logic [5:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] quotient;
    logic [5:0]  remainder;
    logic        div_by_zero;
    logic        q_ovf;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    div12x6_seq #(.N(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .q_ovf       (q_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [11:0] dd, input logic [5:0] dv, input int exp_lat,
                         input logic [11:0] eq, input logic [5:0] er, input logic edz,
                         input logic eovf, input int hold, input int pre);
        int lat;
        int t;
        repeat (pre) begin
            @(posedge clk);
            #1;
        end
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        dividend = dd;
        divisor  = dv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 12'($urandom);
        divisor  = 6'($urandom);
        check("in_ready_busy", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("div_by_zero", div_by_zero, edz);
        check("q_ovf", q_ovf, eovf);
        if (dv != 0) begin
            check("identity", 32'(quotient) * 32'(dv) + 32'(remainder), 32'(dd));
            check("rem_lt_div", 32'(remainder < dv), 1);
        end
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            dividend = 12'd5;
            divisor  = 6'd1;
            @(posedge clk);
            #1;
            check("hold_valid", out_valid, 1);
            check("hold_quotient", quotient, eq);
            check("hold_remainder", remainder, er);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_drop", out_valid, 0);
        check("in_ready_back", in_ready, 1);
        if (hold > 0) begin
            @(posedge clk);
            #1;
            check("no_stray_accept", in_ready, 1);
        end
    endtask

    initial begin
        logic [11:0] rdd;
        logic [11:0] req;
        int          t;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_quotient", quotient, 0);
        check("rst_flags", {div_by_zero, q_ovf}, 0);
        #11;
        rst = 1'b0;
        #1;
        check("in_ready_before_edge", in_ready, 0);
        @(posedge clk);
        #1;
        check("in_ready_after_edge", in_ready, 1);

        do_op(12'd3969, 6'd63, 12, 12'd63,   6'd0,  1'b0, 1'b0, 0, 0);
        do_op(12'd1000, 6'd7,  12, 12'd142,  6'd6,  1'b0, 1'b1, 0, 0);
        do_op(12'd100,  6'd0,  1,  12'd4095, 6'd36, 1'b1, 1'b1, 0, 0);
        do_op(12'd4095, 6'd1,  12, 12'd4095, 6'd0,  1'b0, 1'b1, 5, 0);
        do_op(12'd0,    6'd5,  12, 12'd0,    6'd0,  1'b0, 1'b0, 0, 1);

        // Abort mid-run with reset, then confirm no stale result appears.
        in_valid = 1'b1;
        dividend = 12'd2000;
        divisor  = 6'd45;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        t = 0;
        while (!in_ready && t < 5) begin
            @(posedge clk);
            #1;
            check("abort_no_valid", out_valid, 0);
            t++;
        end
        do_op(12'd2000, 6'd45, 12, 12'd44, 6'd20, 1'b0, 1'b0, 0, 0);

        for (int dv = 1; dv < 64; dv++) begin
            rdd = 12'($urandom_range(0, 4095));
            req = rdd / 12'(dv);
            do_op(rdd, 6'(dv), 12, req, 6'(rdd % 12'(dv)), 1'b0, (req > 12'd63),
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
